// File: rtl/pac_quarter.sv
// pac_quarter: 3-stage quarter-wave sine phase-to-amplitude converter with a run-time loadable table.
// Define PAC_COS_EN to add a cosine channel (second read port, cos_amp output).
module pac_quarter #(
  parameter int PHASE_W = 16,
  parameter int ADDR_W = 12,
  parameter int AMP_W = 16
) (
  input logic sys_clk,
  input logic reset,
  input logic en,
  input logic in_valid,
  input logic [PHASE_W-1:0] phase,
  input logic mute,
  input logic ld_we,
  input logic [ADDR_W-1:0] ld_addr,
  input logic [AMP_W-2:0] ld_data,
  output logic out_valid,
  output logic [AMP_W-1:0] sin_amp
`ifdef PAC_COS_EN
  ,
  output logic [AMP_W-1:0] cos_amp
`endif
);
  logic [1:0] q;
  logic [ADDR_W-1:0] idx;
  logic [AMP_W-2:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] s_addr;
  logic [AMP_W-2:0] s_rd;
  logic s_neg1, s_neg2, m1, m2, v1, v2;
  assign q = phase[PHASE_W-1 -: 2];
  assign idx = phase[PHASE_W-3 -: ADDR_W];
  generate
    if (PHASE_W > ADDR_W + 2) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^phase[PHASE_W-ADDR_W-3:0];
    end
  endgenerate
  function automatic logic [AMP_W-1:0] signed_amp(input logic [AMP_W-2:0] mag, input logic neg, input logic mt);
    logic [AMP_W-1:0] z;
    z = {1'b0, mag};
    return mt ? '0 : neg ? ~z + 1'b1 : z;
  endfunction
  // table writes ignore en and reset; reads are read-first via non-blocking capture
  always_ff @(posedge sys_clk)
    if (ld_we) mem[ld_addr] <= ld_data;
  always_ff @(posedge sys_clk)
    if (en) s_rd <= mem[s_addr];
  always_ff @(posedge sys_clk)
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      sin_amp <= '0;
    end else if (en) begin
      s_addr <= q[0] ? ~idx : idx;
      s_neg1 <= q[1];
      m1 <= mute;
      v1 <= in_valid;
      s_neg2 <= s_neg1;
      m2 <= m1;
      v2 <= v1;
      out_valid <= v2;
      if (v2) sin_amp <= signed_amp(s_rd, s_neg2, m2);
    end
`ifdef PAC_COS_EN
  logic [1:0] qc;
  logic [ADDR_W-1:0] c_addr;
  logic [AMP_W-2:0] c_rd;
  logic c_neg1, c_neg2;
  assign qc = q + 2'd1;
  always_ff @(posedge sys_clk)
    if (en) c_rd <= mem[c_addr];
  always_ff @(posedge sys_clk)
    if (reset) begin
      cos_amp <= '0;
    end else if (en) begin
      c_addr <= qc[0] ? ~idx : idx;
      c_neg1 <= qc[1];
      c_neg2 <= c_neg1;
      if (v2) cos_amp <= signed_amp(c_rd, c_neg2, m2);
    end
`endif
endmodule

// File: tb/tb_pac_quarter.sv
// tb_pac_quarter: scoreboard bench for pac_quarter (default parameters, optional PAC_COS_EN).
module tb_pac_quarter;
  logic sys_clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  logic in_valid = 1'b0;
  logic mute = 1'b0;
  logic ld_we = 1'b0;
  logic [15:0] phase = '0;
  logic [11:0] ld_addr = '0;
  logic [14:0] ld_data = '0;
  logic out_valid;
  logic [15:0] sin_amp;
`ifdef PAC_COS_EN
  logic [15:0] cos_amp;
`endif
  typedef struct packed {
    logic [15:0] s_exp;
    logic [15:0] c_exp;
    logic [31:0] cy;
    logic lat;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] cyc = '0;
  logic adv = 1'b0;
  logic [14:0] tbl [4096];

  pac_quarter dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .en(en),
    .in_valid(in_valid),
    .phase(phase),
    .mute(mute),
    .ld_we(ld_we),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .out_valid(out_valid),
    .sin_amp(sin_amp)
`ifdef PAC_COS_EN
    ,
    .cos_amp(cos_amp)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    adv <= en | reset;
    if (reset) sb.delete();
  end

  // a new output exists only after an edge where the pipeline advanced
  always @(negedge sys_clk)
    if (adv && out_valid) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL stale_output: sin_amp=%h out_valid=1 but no sample expected", sin_amp);
      end else begin
        e = sb.pop_front();
        if (sin_amp !== e.s_exp) begin
          errors++;
          $display("FAIL sb_sin: got %h expected %h", sin_amp, e.s_exp);
        end
`ifdef PAC_COS_EN
        checks++;
        if (cos_amp !== e.c_exp) begin
          errors++;
          $display("FAIL sb_cos: got %h expected %h", cos_amp, e.c_exp);
        end
`endif
        if (e.lat) begin
          checks++;
          if (cyc - e.cy !== 32'd3) begin
            errors++;
            $display("FAIL latency: got %0d cycles expected 3", cyc - e.cy);
          end
        end
      end
    end

  function automatic logic [15:0] model(input logic [15:0] ph, input logic mt, input logic cs);
    logic [1:0] qq;
    logic [11:0] ix;
    logic [15:0] m;
    qq = ph[15:14] + {1'b0, cs};
    ix = ph[13:2];
    if (qq[0]) ix = ~ix;
    m = {1'b0, tbl[ix]};
    if (mt) return 16'h0000;
    return qq[1] ? 16'(17'h0 - {1'b0, m}) : m;
  endfunction

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic load(input logic [11:0] a, input logic [14:0] d);
    ld_we = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_we = 1'b0;
    tbl[a] = d;
  endtask

  task automatic drive(input logic [15:0] ph, input logic mt, input logic [15:0] es, input logic [15:0] ec, input logic lat);
    phase = ph;
    mute = mt;
    in_valid = 1'b1;
    if (en && !reset) sb.push_back('{s_exp: es, c_exp: ec, cy: cyc, lat: lat});
    step();
    in_valid = 1'b0;
    mute = 1'b0;
  endtask

  task automatic drivem(input logic [15:0] ph, input logic mt);
    drive(ph, mt, model(ph, mt, 1'b0), model(ph, mt, 1'b1), 1'b0);
  endtask

  task automatic check_out(input string name, input logic v, input logic [15:0] s);
    checks++;
    if (out_valid !== v || sin_amp !== s) begin
      errors++;
      $display("FAIL %s: out_valid=%b sin_amp=%h expected out_valid=%b sin_amp=%h", name, out_valid, sin_amp, v, s);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || sin_amp !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b sin_amp=%h expected 0/0000", out_valid, sin_amp);
    end
`ifdef PAC_COS_EN
    checks++;
    if (cos_amp !== 16'h0000) begin
      errors++;
      $display("FAIL reset_cos: got %h expected 0000", cos_amp);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_quadrant();
    load(12'h000, 15'h0064);
    load(12'hFFF, 15'h7FFF);
    drive(16'h0000, 1'b0, 16'h0064, 16'h7FFF, 1'b1);
    drive(16'h4000, 1'b0, 16'h7FFF, 16'hFF9C, 1'b1);
    drive(16'h8000, 1'b0, 16'hFF9C, 16'h8001, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || sin_amp !== 16'h0064) begin
      errors++;
      $display("FAIL quad0: out_valid=%b sin_amp=%h expected 1/0064", out_valid, sin_amp);
    end
`ifdef PAC_COS_EN
    checks++;
    if (cos_amp !== 16'h7FFF) begin
      errors++;
      $display("FAIL cos_align: got %h expected 7fff", cos_amp);
    end
`endif
    drive(16'hC000, 1'b0, 16'h8001, 16'h0064, 1'b1);
    checks++;
    if (sin_amp !== 16'h7FFF) begin
      errors++;
      $display("FAIL quad1: got %h expected 7fff", sin_amp);
    end
    step();
    checks++;
    if (sin_amp !== 16'hFF9C) begin
      errors++;
      $display("FAIL quad2: got %h expected ff9c", sin_amp);
    end
    step();
    checks++;
    if (sin_amp !== 16'h8001) begin
      errors++;
      $display("FAIL quad3: got %h expected 8001", sin_amp);
    end
    repeat (3) step();
    checks++;
    if (out_valid !== 1'b0 || sin_amp !== 16'h8001) begin
      errors++;
      $display("FAIL bubble_hold: out_valid=%b sin_amp=%h expected 0/8001", out_valid, sin_amp);
    end
  endtask

  task automatic test_truncation();
    drive(16'h0003, 1'b0, 16'h0064, 16'h7FFF, 1'b1);
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || sin_amp !== 16'h0064) begin
      errors++;
      $display("FAIL truncation: out_valid=%b sin_amp=%h expected 1/0064", out_valid, sin_amp);
    end
    repeat (2) step();
  endtask

  task automatic test_stall();
    logic hv;
    logic [15:0] hs;
    load(12'h020, 15'h0123);
    load(12'h021, 15'h0456);
    load(12'h022, 15'h0789);
    load(12'h023, 15'h0ABC);
    load(12'hFDF, 15'h1001);
    load(12'hFDE, 15'h2002);
    load(12'hFDD, 15'h3003);
    load(12'hFDC, 15'h4004);
    drivem(16'h0080, 1'b0);
    drivem(16'h8084, 1'b0);
    drivem(16'h7F74, 1'b0);
    en = 1'b0;
    hv = out_valid;
    hs = sin_amp;
    phase = 16'h1234;
    in_valid = 1'b1;
    repeat (5) begin
      step();
      checks++;
      if (out_valid !== hv || sin_amp !== hs) begin
        errors++;
        $display("FAIL stall_freeze: out_valid=%b sin_amp=%h expected %b/%h", out_valid, sin_amp, hv, hs);
      end
    end
    in_valid = 1'b0;
    en = 1'b1;
    drivem(16'hFF70, 1'b0);
    repeat (4) step();
  endtask

  task automatic test_mute();
    drive(16'h4000, 1'b1, 16'h0000, 16'h0000, 1'b1);
    step();
    step();
    check_out("mute", 1'b1, 16'h0000);
    repeat (2) step();
  endtask

  task automatic test_reset_midstream();
    load(12'hFCF, 15'h0DEF);
    drivem(16'h0080, 1'b0);
    drivem(16'h8084, 1'b0);
    drivem(16'h7F74, 1'b0);
    reset = 1'b1;
    ld_we = 1'b1;
    ld_addr = 12'h030;
    ld_data = 15'h0ABC;
    step();
    reset = 1'b0;
    ld_we = 1'b0;
    tbl[12'h030] = 15'h0ABC;
    check_out("reset_flush", 1'b0, 16'h0000);
    repeat (4) begin
      step();
      check_out("no_stale", 1'b0, 16'h0000);
    end
    drive(16'h00C0, 1'b0, 16'h0ABC, 16'h0DEF, 1'b1);
    step();
    step();
    check_out("write_during_reset", 1'b1, 16'h0ABC);
    repeat (2) step();
  endtask

  task automatic test_rdw();
    load(12'h010, 15'h1111);
    load(12'hFEF, 15'h0333);
    drive(16'h0040, 1'b0, 16'h1111, 16'h0333, 1'b1);
    ld_we = 1'b1;
    ld_addr = 12'h010;
    ld_data = 15'h2222;
    drive(16'h0040, 1'b0, 16'h2222, 16'h0333, 1'b1);
    ld_we = 1'b0;
    tbl[12'h010] = 15'h2222;
    step();
    check_out("rdw_old", 1'b1, 16'h1111);
    step();
    check_out("rdw_new", 1'b1, 16'h2222);
    repeat (3) step();
  endtask

  task automatic test_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d samples never produced, expected 0", sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) tbl[i] = '0;
    test_reset();
    test_quadrant();
    test_truncation();
    test_stall();
    test_mute();
    test_reset_midstream();
    test_rdw();
    test_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pac_quarter.md
# pac_quarter

Parametrised, pipelined phase-to-amplitude converter for the DDS datapath. It sits between the phase accumulator and the DAC/mixer stage. It holds a loadable quarter-wave sine magnitude table and uses quadrant symmetry (address mirroring plus sign negation) to produce a full-period two's-complement sine. The table is written at run time through a dedicated load port, and a flow-control enable stalls the whole pipeline.

## Interface
- PHASE_W, 16, phase input width; must satisfy PHASE_W >= ADDR_W+2
- ADDR_W, 12, quarter-table address width; table depth is 2^ADDR_W entries
- AMP_W, 16, signed output width; table entries are AMP_W-1 bits unsigned

- sys_clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- en  in  1  pipeline advance; low freezes all pipeline stages
- in_valid  in  1  phase sample valid
- phase  in  PHASE_W  phase word; top ADDR_W+2 bits used, rest truncated
- mute  in  1  sampled with phase; forces that sample's output to 0
- ld_we  in  1  table write strobe
- ld_addr  in  ADDR_W  table write address
- ld_data  in  AMP_W-1  table write data (magnitude)
- out_valid  out  1  sin_amp (and cos_amp) valid
- sin_amp  out  AMP_W  signed sine amplitude
- cos_amp  out  AMP_W  signed cosine amplitude (only with PAC_COS_EN)

## Operation
- Phase decode:
  - q = phase[PHASE_W-1:PHASE_W-2].
  - idx = phase[PHASE_W-3 -: ADDR_W].
- Per quadrant:
  - q=0: addr=idx, positive.
  - q=1: addr=~idx, positive.
  - q=2: addr=idx, negate.
  - q=3: addr=~idx, negate.
- Table is behavioural dual-port memory: one write port (ld_*), one read port per output channel.
- Table contents are not cleared by reset. Contents are undefined until loaded.
- Write occurs on any cycle with ld_we=1, independent of en and reset.
- Read-during-write to the same address returns old data (read-first).
- Output arithmetic:
  - mag is zero-extended to AMP_W.
  - Result is mag when positive; (~mag)+1 in AMP_W bits when negated.
  - Negation can never overflow, because magnitude is at most 2^(AMP_W-1)-1.
  - Magnitude 0 negated yields 0.
- Mute: the muted sample still propagates with out_valid=1, but its amplitude is 0.
- in_valid=0 samples propagate as bubbles (out_valid=0). Amplitude registers hold their previous value.

## Timing
- Pipeline stages:
  - S1 registers addr, neg, mute, valid.
  - S2 registers table read data.
  - S3 registers the signed output and out_valid.
- Latency is 3 sys_clk cycles from phase/in_valid sampled with en=1 to out_valid/sin_amp, with en held high.
- Throughput is one sample per cycle.
- en=0:
  - Every stage register, including the S2 read register, holds.
  - out_valid holds its current value.
  - No sample is lost or duplicated.
  - Resumption continues exactly where the pipeline stopped.
- Reset (synchronous, wins over en):
  - S1–S3 valid bits cleared.
  - out_valid=0, sin_amp=0, cos_amp=0 on the cycle after reset is sampled high.
  - Reset mid-stream discards all in-flight samples.
  - Any ld_we in the same cycle still writes.
- A table write at cycle t is visible to reads issued from S1 in cycle t+1 or later.

## Configuration
- PAC_COS_EN defined:
  - Adds the cos_amp port and a second read port.
  - Cosine uses quadrant q+1 (mod 4) with the same idx and the same mirror/negate rules.
  - Same latency, stall and mute behaviour as sine, aligned to the same out_valid.
- PAC_COS_EN undefined: no cos_amp port and no second read port; sine-only behaviour is unchanged.

## Test plan
All scenarios use default parameters.
- Quadrant symmetry:
  - Stimulus: load addr 0x000=0x0064 and addr 0xFFF=0x7FFF; apply phase 0x0000, 0x4000, 0x8000, 0xC000 back-to-back, en=1.
  - Response: sin_amp 0x0064, 0x7FFF, 0xFF9C, 0x8001 on 4 consecutive cycles, the first 3 cycles after the first input.
- Truncation:
  - Stimulus: phase 0x0003 after the load above.
  - Response: sin_amp 0x0064, identical to phase 0x0000.
- Stall:
  - Stimulus: stream 4 valid samples; drop en for 5 cycles mid-stream.
  - Response: outputs freeze; the 4 results appear in order, none dropped or repeated.
- Mute and reset:
  - Mute: phase 0x4000 with mute=1 -> out_valid=1, sin_amp=0x0000.
  - Reset: assert reset for 1 cycle with 3 samples in flight -> next cycle out_valid=0, sin_amp=0, no stale outputs afterwards.
- Read-during-write:
  - Stimulus: addr 0x010=0x1111; write 0x2222 to addr 0x010 on the same cycle S1 reads addr 0x010.
  - Response: output 0x1111; the next read returns 0x2222.
- PAC_COS_EN:
  - Stimulus: phase 0x0000 with addr 0xFFF=0x7FFF.
  - Response: cos_amp 0x7FFF, aligned with the sine result.
